// File: rtl/bus_bridge_pkg.sv
// Shared types for the bus bridge: request/response payloads and the target-side FSM state.
package bus_bridge_pkg;

    localparam int unsigned BB_ADDR_W            = 16;
    localparam int unsigned BB_DATA_W            = 8;
    localparam int unsigned BT_SPLIT_TIMEOUT_DEF = 8;

    typedef struct packed {
        logic [BB_ADDR_W-1:0] addr;
        logic                 is_write;
        logic [BB_DATA_W-1:0] write_data;
    } bus_bridge_req_t;

    typedef struct packed {
        logic                 is_write;
        logic [BB_DATA_W-1:0] read_data;
    } bus_bridge_resp_t;

    typedef enum logic [2:0] {
        BT_IDLE       = 3'd0,
        BT_CAPTURE    = 3'd1,
        BT_ISSUE      = 3'd2,
        BT_WAIT_RESP  = 3'd3,
        BT_SPLIT_WAIT = 3'd4,
        BT_SPLIT_REQ  = 3'd5,
        BT_RESPOND    = 3'd6
    } target_state_t;

endpackage

// File: rtl/bus_bridge_target_if_if.sv
// Serial-bus target port plus bridge request/response channels seen by the target endpoint.
interface bus_bridge_target_if_if;
    import bus_bridge_pkg::*;

    logic                 target_sel;
    logic [BB_ADDR_W-1:0] target_addr_in;
    logic                 target_addr_in_valid;
    logic [BB_DATA_W-1:0] target_data_in;
    logic                 target_data_in_valid;
    logic                 target_rw;
    logic                 target_ready;
    logic [BB_DATA_W-1:0] target_data_out;
    logic                 target_data_out_valid;
    logic                 target_ack;
    logic                 target_split_ack;
    logic                 target_split_req;
    logic                 target_split_grant;

    logic                 req_valid;
    logic                 req_ready;
    bus_bridge_req_t      req_payload;

    logic                 resp_valid;
    logic                 resp_ready;
    bus_bridge_resp_t     resp_payload;

    // Endpoint side
    modport slave (
        input  target_sel, target_addr_in, target_addr_in_valid,
               target_data_in, target_data_in_valid, target_rw,
               target_split_grant, req_ready, resp_valid, resp_payload,
        output target_ready, target_data_out, target_data_out_valid,
               target_ack, target_split_ack, target_split_req,
               req_valid, req_payload, resp_ready
    );

    // Bus initiator / bridge side
    modport master (
        output target_sel, target_addr_in, target_addr_in_valid,
               target_data_in, target_data_in_valid, target_rw,
               target_split_grant, req_ready, resp_valid, resp_payload,
        input  target_ready, target_data_out, target_data_out_valid,
               target_ack, target_split_ack, target_split_req,
               req_valid, req_payload, resp_ready
    );

endinterface

// File: rtl/bus_bridge_target_if.sv
// Target endpoint of the bus bridge: captures a bus transaction, forwards it to the bridge,
// and returns ack/read data, splitting the transfer when the bridge response is slow.
module bus_bridge_target_if
    import bus_bridge_pkg::*;
#(
    parameter int unsigned SPLIT_TIMEOUT = BT_SPLIT_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_bridge_target_if_if.slave  bus
);

    // Counter keeps at least one bit so SPLIT_TIMEOUT=0 still elaborates
    localparam int unsigned     CNT_W    = (SPLIT_TIMEOUT == 0) ? 1 : $clog2(SPLIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SPLIT_TIMEOUT == 0) ? 0 : SPLIT_TIMEOUT - 1);

    target_state_t        state_q, state_d;
    bus_bridge_req_t      req_q, req_d;
    logic [BB_DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 split_ack_d;
    logic                 rsp_read_d;

    logic                 req_valid_q;
    logic                 resp_ready_q;
    logic                 split_ack_q;
    logic                 split_req_q;
    logic                 ack_q;
    logic                 dout_valid_q;
    logic [BB_DATA_W-1:0] dout_q;

    logic                 unused_resp_is_write;
    assign unused_resp_is_write = bus.resp_payload.is_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BT_IDLE;
        else     state_q <= state_d;
    end

    // Next-state, capture and split-timeout decisions
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        split_ack_d = 1'b0;

        case (state_q)
            BT_IDLE: begin
                if (bus.target_sel && bus.target_addr_in_valid) begin
                    req_d.addr       = bus.target_addr_in;
                    req_d.is_write   = bus.target_rw;
                    req_d.write_data = '0;
                    if (!bus.target_rw) begin
                        state_d = BT_ISSUE;
                    end else if (bus.target_data_in_valid) begin
                        req_d.write_data = bus.target_data_in;
                        state_d          = BT_ISSUE;
                    end else begin
                        state_d = BT_CAPTURE;
                    end
                end
            end
            BT_CAPTURE: begin
                if (!bus.target_sel) begin
                    state_d = BT_IDLE;
                end else if (bus.target_data_in_valid) begin
                    req_d.write_data = bus.target_data_in;
                    state_d          = BT_ISSUE;
                end
            end
            BT_ISSUE: begin
                if (bus.req_ready) begin
                    state_d = BT_WAIT_RESP;
                    cnt_d   = '0;
                end
            end
            BT_WAIT_RESP: begin
                // A response arriving in the timeout cycle takes priority over the split
                if (bus.resp_valid) begin
                    if (!req_q.is_write) rdata_d = bus.resp_payload.read_data;
                    state_d = BT_RESPOND;
                end else if ((SPLIT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    split_ack_d = 1'b1;
                    state_d     = BT_SPLIT_WAIT;
                end
            end
            BT_SPLIT_WAIT: begin
                if (bus.resp_valid) begin
                    if (!req_q.is_write) rdata_d = bus.resp_payload.read_data;
                    state_d = BT_SPLIT_REQ;
                end
            end
            BT_SPLIT_REQ: begin
                if (bus.target_split_grant) state_d = BT_RESPOND;
            end
            BT_RESPOND: begin
                state_d = BT_IDLE;
            end
            default: begin
                state_d = BT_IDLE;
            end
        endcase

        rsp_read_d = (state_d == BT_RESPOND) && !req_d.is_write;
    end

    // Datapath and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            split_ack_q  <= 1'b0;
            split_req_q  <= 1'b0;
            ack_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            req_q        <= req_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            req_valid_q  <= (state_d == BT_ISSUE);
            resp_ready_q <= (state_d == BT_WAIT_RESP) || (state_d == BT_SPLIT_WAIT);
            split_ack_q  <= split_ack_d;
            split_req_q  <= (state_d == BT_SPLIT_REQ);
            ack_q        <= (state_d == BT_RESPOND);
            dout_valid_q <= rsp_read_d;
            dout_q       <= rsp_read_d ? rdata_d : '0;
        end
    end

    assign bus.target_ready          = (state_q == BT_IDLE);
    assign bus.req_valid             = req_valid_q;
    assign bus.req_payload           = req_q;
    assign bus.resp_ready            = resp_ready_q;
    assign bus.target_split_ack      = split_ack_q;
    assign bus.target_split_req      = split_req_q;
    assign bus.target_ack            = ack_q;
    assign bus.target_data_out_valid = dout_valid_q;
    assign bus.target_data_out       = dout_q;

endmodule

// File: tb/tb_bus_bridge_target_if.sv
// Scoreboard bench for bus_bridge_target_if: a split-enabled instance (timeout 4) and a
// split-disabled instance (timeout 0) share one driver; a monitor checks every output event.
module tb_bus_bridge_target_if;
    import bus_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_bridge_target_if_if bi ();
    bus_bridge_target_if_if bz ();

    bus_bridge_target_if #(.SPLIT_TIMEOUT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bi));
    bus_bridge_target_if #(.SPLIT_TIMEOUT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bz));

    logic             use0;
    logic             d_sel, d_addr_v, d_data_v, d_rw, d_req_ready, d_resp_valid, d_grant;
    logic [15:0]      d_addr;
    logic [7:0]       d_data;
    bus_bridge_resp_t d_resp;

    assign bi.target_sel           = !use0 && d_sel;
    assign bz.target_sel           =  use0 && d_sel;
    assign bi.target_addr_in_valid = !use0 && d_addr_v;
    assign bz.target_addr_in_valid =  use0 && d_addr_v;
    assign bi.target_data_in_valid = !use0 && d_data_v;
    assign bz.target_data_in_valid =  use0 && d_data_v;
    assign bi.req_ready            = !use0 && d_req_ready;
    assign bz.req_ready            =  use0 && d_req_ready;
    assign bi.resp_valid           = !use0 && d_resp_valid;
    assign bz.resp_valid           =  use0 && d_resp_valid;
    assign bi.target_split_grant   = !use0 && d_grant;
    assign bz.target_split_grant   =  use0 && d_grant;
    assign bi.target_addr_in = d_addr;
    assign bz.target_addr_in = d_addr;
    assign bi.target_data_in = d_data;
    assign bz.target_data_in = d_data;
    assign bi.target_rw      = d_rw;
    assign bz.target_rw      = d_rw;
    assign bi.resp_payload   = d_resp;
    assign bz.resp_payload   = d_resp;

    logic            m_ready, m_req_valid, m_resp_ready, m_ack, m_dvalid, m_split_ack, m_split_req;
    logic [7:0]      m_dout;
    bus_bridge_req_t m_pay;
    assign m_ready      = use0 ? bz.target_ready          : bi.target_ready;
    assign m_req_valid  = use0 ? bz.req_valid             : bi.req_valid;
    assign m_resp_ready = use0 ? bz.resp_ready            : bi.resp_ready;
    assign m_ack        = use0 ? bz.target_ack            : bi.target_ack;
    assign m_dvalid     = use0 ? bz.target_data_out_valid : bi.target_data_out_valid;
    assign m_split_ack  = use0 ? bz.target_split_ack      : bi.target_split_ack;
    assign m_split_req  = use0 ? bz.target_split_req      : bi.target_split_req;
    assign m_dout       = use0 ? bz.target_data_out       : bi.target_data_out;
    assign m_pay        = use0 ? bz.req_payload           : bi.req_payload;

    // Expected outcome of one transaction; offsets are cycles after the request handshake
    typedef struct {
        bus_bridge_req_t pay;
        bit              is_write;
        logic [7:0]      rdata;
        int              ack_off;
        int              split_off;
        int              sreq_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   hs_cyc  = 0;
    bit   hs_done = 1'b0;
    int   split_off = -1;
    int   sreq_cnt  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: matches every DUT output event against the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            hs_done   = 1'b0;
            split_off = -1;
            sreq_cnt  = 0;
        end else begin
            if (exp_q.size() == 0 || hs_done) begin
                chk("req_valid_unexpected", int'(m_req_valid), 0);
            end else if (m_req_valid) begin
                chk("req_payload", int'(m_pay), int'(exp_q[0].pay));
                if (d_req_ready) begin
                    hs_done = 1'b1;
                    hs_cyc  = cyc;
                end
            end
            if (!hs_done) begin
                chk("ack_unexpected", int'(m_ack), 0);
                chk("split_ack_unexpected", int'(m_split_ack), 0);
                chk("split_req_unexpected", int'(m_split_req), 0);
            end else begin
                if (m_split_ack) split_off = (split_off == -1) ? cyc - hs_cyc : -2;
                if (m_split_req) sreq_cnt++;
                if (m_ack) begin
                    e = exp_q.pop_front();
                    chk("ack_latency", cyc - hs_cyc, e.ack_off);
                    chk("split_ack_offset", split_off, e.split_off);
                    chk("split_req_cycles", sreq_cnt, e.sreq_cnt);
                    chk("data_out_valid", int'(m_dvalid), int'(!e.is_write));
                    if (!e.is_write) chk("read_data", int'(m_dout), int'(e.rdata));
                    hs_done   = 1'b0;
                    split_off = -1;
                    sreq_cnt  = 0;
                end
            end
            if (!m_ack) chk("data_out_valid_without_ack", int'(m_dvalid), 0);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drv();
        d_sel = 1'b0; d_addr_v = 1'b0; d_data_v = 1'b0; d_rw = 1'b0;
        d_req_ready = 1'b0; d_resp_valid = 1'b0; d_grant = 1'b0;
        d_addr = '0; d_data = '0; d_resp = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_target_ready"}, int'(m_ready), 1);
        chk({tag, "_req_valid"}, int'(m_req_valid), 0);
        chk({tag, "_req_payload"}, int'(m_pay), 0);
        chk({tag, "_resp_ready"}, int'(m_resp_ready), 0);
        chk({tag, "_ack"}, int'(m_ack), 0);
        chk({tag, "_data_out_valid"}, int'(m_dvalid), 0);
        chk({tag, "_data_out"}, int'(m_dout), 0);
        chk({tag, "_split_ack"}, int'(m_split_ack), 0);
        chk({tag, "_split_req"}, int'(m_split_req), 0);
    endtask

    task automatic recover();
        clear_drv();
        rst = 1'b1;
        #1;
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_ready && n < 20) begin
            step();
            n++;
        end
        if (!m_ready) begin
            chk("idle_timeout", int'(m_ready), 1);
            recover();
        end
    endtask

    // One transaction; d = response delay after entering the wait, g = grant delay
    task automatic txn(input bit w, input logic [15:0] a, input logic [7:0] wd, input bit same,
                       input int rdy, input int d, input logic [7:0] rd, input int g,
                       input bit noise);
        int   st    = use0 ? 0 : 4;
        bit   split = (st != 0) && (d >= st);
        int   lo    = 0;
        int   n     = 0;
        exp_t e;
        chk("ready_at_start", int'(m_ready), 1);
        e.pay.addr       = a;
        e.pay.is_write   = w;
        e.pay.write_data = w ? wd : 8'h00;
        e.is_write       = w;
        e.rdata          = rd;
        e.ack_off        = split ? d + 3 + g : d + 2;
        e.split_off      = split ? st + 1 : -1;
        e.sreq_cnt       = split ? g + 1 : 0;
        exp_q.push_back(e);

        d_sel = 1'b1; d_addr_v = 1'b1; d_addr = a; d_rw = w;
        d_data = wd; d_data_v = w && same; d_req_ready = (rdy == 0);
        step();
        d_addr_v = 1'b0;
        d_addr   = 16'($urandom);
        if (w && !same) begin
            d_data_v = 1'b1;
            step();
        end
        d_sel = 1'b0; d_data_v = 1'b0; d_data = 8'($urandom);

        while (1) begin
            if (m_req_valid) begin
                if (d_req_ready) break;
                if (lo >= rdy) begin
                    d_req_ready = 1'b1;
                    break;
                end
                lo++;
            end
            n++;
            if (n > 40) begin
                chk("req_valid_timeout", int'(m_req_valid), 1);
                recover();
                return;
            end
            step();
        end
        step();
        d_req_ready = 1'b0;
        if (noise) begin
            d_sel = 1'b1; d_addr_v = 1'b1; d_rw = 1'($urandom);
        end
        repeat (d) step();
        d_sel = 1'b0; d_addr_v = 1'b0;
        d_resp.read_data = rd;
        d_resp.is_write  = 1'($urandom);
        d_resp_valid     = 1'b1;
        step();
        d_resp_valid = 1'b0;
        d_resp       = bus_bridge_resp_t'(9'($urandom));
        if (split) begin
            repeat (g) step();
            d_grant = 1'b1;
            step();
            d_grant = 1'b0;
        end
        wait_idle();
    endtask

    // Write address without data, then deselect: no bridge request may follow
    task automatic abort_write(input logic [15:0] a);
        chk("ready_before_abort", int'(m_ready), 1);
        d_sel = 1'b1; d_addr_v = 1'b1; d_addr = a; d_rw = 1'b1; d_data_v = 1'b0;
        step();
        d_addr_v = 1'b0; d_sel = 1'b0;
        step();
        chk("ready_after_abort", int'(m_ready), 1);
        repeat (3) step();
    endtask

    // Read that is reset while waiting for the bridge response
    task automatic reset_in_wait(input logic [15:0] a);
        exp_t e;
        chk("ready_before_rst_txn", int'(m_ready), 1);
        e.pay.addr = a; e.pay.is_write = 1'b0; e.pay.write_data = 8'h00;
        e.is_write = 1'b0; e.rdata = 8'h00; e.ack_off = 0; e.split_off = -1; e.sreq_cnt = 0;
        exp_q.push_back(e);
        d_sel = 1'b1; d_addr_v = 1'b1; d_addr = a; d_rw = 1'b0; d_req_ready = 1'b1;
        step();
        d_sel = 1'b0; d_addr_v = 1'b0;
        step();
        d_req_ready = 1'b0;
        step();
        chk("resp_ready_in_wait", int'(m_resp_ready), 1);
        chk("ready_low_in_wait", int'(m_ready), 0);
        rst = 1'b1;
        #1;
        check_quiet("mid_rst");
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        use0 = 1'b0;
        clear_drv();
        rst = 1'b1;
        #7;
        check_quiet("reset");
        step();
        rst = 1'b0;
        step();

        txn(1'b1, 16'h1234, 8'hA5, 1'b1, 0, 0, 8'h00, 0, 1'b0);
        txn(1'b0, 16'h0040, 8'h00, 1'b1, 0, 2, 8'h3C, 0, 1'b0);
        txn(1'b0, 16'h0100, 8'h00, 1'b1, 0, 10, 8'h77, 3, 1'b0);
        abort_write(16'h0300);
        txn(1'b0, 16'h0200, 8'h00, 1'b1, 0, 1, 8'h96, 0, 1'b0);
        txn(1'b1, 16'hBEEF, 8'h5A, 1'b0, 5, 1, 8'h00, 0, 1'b0);
        reset_in_wait(16'h0404);
        txn(1'b0, 16'h0500, 8'h00, 1'b1, 0, 3, 8'h11, 0, 1'b0);
        txn(1'b0, 16'h0600, 8'h00, 1'b1, 0, 4, 8'h22, 0, 1'b0);
        txn(1'b1, 16'h0700, 8'hC4, 1'b1, 2, 6, 8'h00, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), 16'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
        end

        use0 = 1'b1;
        step();
        txn(1'b0, 16'h0ABC, 8'h00, 1'b1, 0, 50, 8'hC3, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            txn(1'($urandom), 16'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 12)), 8'($urandom),
                0, 1'($urandom));
        end

        repeat (5) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
